// File: rtl/mux4_pkg.sv
// Shared types for the registered 4-to-1 select mux.
// Holds the select enum and the input count.
package mux4_pkg;

    localparam int NUM_IN = 4;

    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2,
        SEL_D = 2'd3
    } sel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Ports: clk, rst (sync, high), clr (zero), inc (+1 unless full), q (count).
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            // clear wins over a same-cycle increment
            r_q <= '0;
        end else if (inc && (r_q != {CNT_W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/mux4_sel_reg.sv
// Registered 4-to-1 mux on {s1,s2} with valid flag and per-input counters.
// Ports: clk, rst (sync, high), a..d, s1/s2, in_valid, cnt_clr in;
//        y, y_valid, sel_q, cnt_a..cnt_d out; y_par when MUX4_PARITY_EN defined.
module mux4_sel_reg
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       sel_q,
`ifdef MUX4_PARITY_EN
    output logic             y_par,
`endif
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    sel_t              w_sel;
    logic [WIDTH-1:0]  w_data;
    logic [NUM_IN-1:0] w_inc;
    logic [CNT_W-1:0]  w_cnt [NUM_IN];

    logic [WIDTH-1:0]  r_y;
    logic              r_y_valid;
    logic [1:0]        r_sel_q;

    // Unknown select bits fall to the default arm and pick a.
    always_comb begin
        w_sel = SEL_A;
        case ({s1, s2})
            2'b01:   w_sel = SEL_B;
            2'b10:   w_sel = SEL_C;
            2'b11:   w_sel = SEL_D;
            default: w_sel = SEL_A;
        endcase
    end

    always_comb begin
        w_data = a;
        case (w_sel)
            SEL_B:   w_data = b;
            SEL_C:   w_data = c;
            SEL_D:   w_data = d;
            default: w_data = a;
        endcase
    end

    always_comb begin
        w_inc = '0;
        if (in_valid) begin
            w_inc[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_sel_q   <= 2'b00;
        end else begin
            r_y_valid <= in_valid;
            if (in_valid) begin
                r_y     <= w_data;
                r_sel_q <= w_sel;
            end
        end
    end

`ifdef MUX4_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (in_valid) begin
            r_par <= ^w_data;
        end
    end

    assign y_par = r_par;
`endif

    for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
        sat_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk(clk),
            .rst(rst),
            .clr(cnt_clr),
            .inc(w_inc[g]),
            .q  (w_cnt[g])
        );
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign sel_q   = r_sel_q;
    assign cnt_a   = w_cnt[SEL_A];
    assign cnt_b   = w_cnt[SEL_B];
    assign cnt_c   = w_cnt[SEL_C];
    assign cnt_d   = w_cnt[SEL_D];

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Bench for mux4_sel_reg: directed cases plus random traffic vs a model.
// Optional y_par checked when MUX4_PARITY_EN is defined.
module tb_mux4_sel_reg;

    localparam int W   = 8;
    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b, c, d;
    logic          s1, s2;
    logic          in_valid;
    logic          cnt_clr;
    logic [W-1:0]  y;
    logic          y_valid;
    logic [1:0]    sel_q;
    logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`ifdef MUX4_PARITY_EN
    logic          y_par;
`endif

    always #5 clk = ~clk;

    mux4_sel_reg #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .s1      (s1),
        .s2      (s2),
        .in_valid(in_valid),
        .cnt_clr (cnt_clr),
        .y       (y),
        .y_valid (y_valid),
        .sel_q   (sel_q),
`ifdef MUX4_PARITY_EN
        .y_par   (y_par),
`endif
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .cnt_c   (cnt_c),
        .cnt_d   (cnt_d)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [W-1:0] m_y;
    logic         m_v;
    int           m_sel;
    logic         m_par;
    int           m_cnt [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("y", 32'(y), 32'(m_y));
        chk("y_valid", 32'(y_valid), 32'(m_v));
        chk("sel_q", 32'(sel_q), 32'(m_sel));
        chk("cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
        chk("cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
        chk("cnt_c", 32'(cnt_c), 32'(m_cnt[2]));
        chk("cnt_d", 32'(cnt_d), 32'(m_cnt[3]));
`ifdef MUX4_PARITY_EN
        chk("y_par", 32'(y_par), 32'(m_par));
`endif
    endtask

    // One clock: drive, advance, update model, compare.
    task automatic cyc(input logic r, input logic v, input logic cl,
                       input logic [1:0] s, input logic [W-1:0] da,
                       input logic [W-1:0] db, input logic [W-1:0] dc,
                       input logic [W-1:0] dd);
        logic [W-1:0] din [4];
        int k;
        rst = r; in_valid = v; cnt_clr = cl;
        s1 = s[1]; s2 = s[0];
        a = da; b = db; c = dc; d = dd;
        din[0] = da; din[1] = db; din[2] = dc; din[3] = dd;
        k = $isunknown(s) ? 0 : int'(s);
        @(posedge clk);
        if (r) begin
            m_y = '0; m_v = 1'b0; m_sel = 0; m_par = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            m_v = v;
            if (v) begin
                m_y   = din[k];
                m_sel = k;
                m_par = ^din[k];
            end
            if (cl) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (v && m_cnt[k] < MAX) begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    initial begin
        m_y = '0; m_v = 1'b0; m_sel = 0; m_par = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        // reset with random inputs
        repeat (2) cyc(1'b1, 1'($urandom), 1'($urandom), 2'($urandom),
                       rnd(), rnd(), rnd(), rnd());
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_cnt_b", 32'(cnt_b), 32'h0);

        // select sweep
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 2'(i), 8'd1, 8'd0, 8'd1, 8'd0);
            chk("sweep_y", 32'(y), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("sweep_v", 32'(y_valid), 32'd1);
        end

        // wide data
        cyc(1'b0, 1'b1, 1'b0, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
        chk("wide_y", 32'(y), 32'h33);
        chk("wide_sel", 32'(sel_q), 32'h2);

        // hold
        cyc(1'b0, 1'b1, 1'b0, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 8'hA5, 8'h5A, 8'hC3, 8'h3C);
        chk("hold_y", 32'(y), 32'h44);
        chk("hold_v", 32'(y_valid), 32'h0);

        // saturation on b, then clear beats same-cycle select
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 8'h0, 8'h0, 8'h0, 8'h0);
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 2'b01, rnd(), rnd(), rnd(), rnd());
        chk("sat_b", 32'(cnt_b), 32'd3);
        chk("sat_a", 32'(cnt_a), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 2'b01, rnd(), rnd(), rnd(), rnd());
        chk("clr_b", 32'(cnt_b), 32'd0);

        // reset mid-stream
        cyc(1'b0, 1'b1, 1'b0, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44);
        cyc(1'b1, 1'b1, 1'b0, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
        chk("mid_rst_y", 32'(y), 32'h0);
        chk("mid_rst_v", 32'(y_valid), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 2'b01, 8'h11, 8'h22, 8'h33, 8'h44);
        chk("post_rst_y", 32'(y), 32'h22);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), 1'($urandom),
                ($urandom_range(0, 19) == 0), 2'($urandom),
                rnd(), rnd(), rnd(), rnd());
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
